card_dealer: RTL and testbench



---
 rtl/blackjack_pkg.sv | 27 ++
 rtl/card_dealer_if.sv | 21 ++
 rtl/lfsr16.sv | 27 ++
 rtl/card_dealer.sv | 129 ++++++++++++
 tb/tb_card_dealer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: dealer FSM states, deck geometry and the
// rank-to-value mapping reused by the hand FSM.
package blackjack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int NUM_RANKS = 13;
  localparam int SUITS     = 4;
  localparam int DECK_SIZE = 52;

  // Ace counts 1, pips count face value, J/Q/K count 10.
  function automatic logic [4:0] rank_value(input logic [3:0] rank);
    if (rank == 4'd0) begin
      return 5'd1;
    end else if (rank <= 4'd9) begin
      return {1'b0, rank} + 5'd1;
    end else begin
      return 5'd10;
    end
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Draw/shuffle handshake between the hand FSM (master) and the card dealer (slave).
interface card_dealer_if;
  logic       req;
  logic       shuffle;
  logic       card_valid;
  logic [4:0] card_value;
  logic [3:0] card_rank;
  logic [5:0] cards_left;
  logic       busy;
  logic       deck_empty;

  modport master (
    output req, shuffle,
    input  card_valid, card_value, card_rank, cards_left, busy, deck_empty
  );

  modport slave (
    input  req, shuffle,
    output card_valid, card_value, card_rank, cards_left, busy, deck_empty
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), reloaded only by reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement from one deck: random rank picks from an LFSR,
// falling back to a linear scan after MAX_TRIES rejected picks.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic          Clock,
  input  logic          reset,
  card_dealer_if.slave  bus
);

  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  state_e                        state_q, state_d;
  logic [7:0]                    try_q, try_d;
  logic [3:0]                    scan_q, scan_d;
  logic [5:0]                    left_q, left_d;
  logic [3:0]                    rank_q, rank_d;
  logic [4:0]                    value_q, value_d;
  logic [NUM_RANKS-1:0][2:0]     cnt_q, cnt_d;

  logic [15:0] lfsr_q;
  logic [15:0] avail;
  logic [3:0]  cand;
  logic [3:0]  lfsr_mod13;
  logic        cand_ok;
  logic        take;
  logic        unused_lfsr_hi;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock (Clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:4];

  assign cand       = (state_q == SCAN) ? scan_q : lfsr_q[3:0];
  assign lfsr_mod13 = (lfsr_q[3:0] >= 4'd13) ? (lfsr_q[3:0] - 4'd13) : lfsr_q[3:0];
  assign cand_ok    = avail[cand];

  // Candidates 13..15 are padding so a raw LFSR nibble can index avail directly.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rank
      if (gi < NUM_RANKS) begin : g_real
        assign avail[gi] = (cnt_q[gi] != 3'(SUITS));
        assign cnt_d[gi] = bus.shuffle ? 3'd0 :
                           (take && (cand == 4'(gi))) ? (cnt_q[gi] + 3'd1) : cnt_q[gi];
      end else begin : g_pad
        assign avail[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    scan_d  = scan_q;
    left_d  = left_q;
    rank_d  = rank_q;
    value_d = value_q;
    take    = 1'b0;

    if (bus.shuffle) begin
      state_d = IDLE;
      left_d  = 6'(DECK_SIZE);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req && (left_q != 6'd0)) begin
            state_d = DRAW;
            try_d   = 8'd0;
          end
        end
        DRAW, SCAN: begin
          if (cand_ok) begin
            take    = 1'b1;
            left_d  = left_q - 6'd1;
            rank_d  = cand;
            value_d = rank_value(cand);
            state_d = DONE;
          end else if (state_q == DRAW) begin
            try_d = try_q + 8'd1;
            if (try_d == TRY_LIMIT) begin
              state_d = SCAN;
              scan_d  = lfsr_mod13;
            end
          end else begin
            scan_d = (scan_q == 4'd12) ? 4'd0 : (scan_q + 4'd1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      try_q   <= 8'd0;
      scan_q  <= 4'd0;
      left_q  <= 6'(DECK_SIZE);
      rank_q  <= 4'd0;
      value_q <= 5'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      try_q   <= try_d;
      scan_q  <= scan_d;
      left_q  <= left_d;
      rank_q  <= rank_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.card_valid = (state_q == DONE);
  assign bus.busy       = (state_q == DRAW) || (state_q == SCAN);
  assign bus.card_value = value_q;
  assign bus.card_rank  = rank_q;
  assign bus.cards_left = left_q;
  assign bus.deck_empty = (left_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Randomised scoreboard bench for card_dealer: two instances (MAX_TRIES 8 and 1)
// checked against a deck-level reference model.
module tb_card_dealer;

  typedef struct {
    logic [3:0] rank;
    logic [4:0] value;
    int         cyc;
    logic [5:0] left;
  } exp_t;

  logic Clock = 1'b0;
  logic reset;
  logic req;
  logic shuffle;
  logic sel;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rem[13];
  int   seen[13];
  int   sum_val;
  int   left_m;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] lfsr_m;

  logic       v_valid, v_busy, v_empty;
  logic [4:0] v_value;
  logic [3:0] v_rank;
  logic [5:0] v_left;

  card_dealer_if bus8();
  card_dealer_if bus1();

  assign bus8.req     = req & ~sel;
  assign bus1.req     = req & sel;
  assign bus8.shuffle = shuffle;
  assign bus1.shuffle = shuffle;

  card_dealer #(.LFSR_SEED(16'hACE1), .MAX_TRIES(8)) dut8 (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus8)
  );

  card_dealer #(.LFSR_SEED(16'hACE1), .MAX_TRIES(1)) dut1 (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus1)
  );

  assign v_valid = sel ? bus1.card_valid : bus8.card_valid;
  assign v_busy  = sel ? bus1.busy       : bus8.busy;
  assign v_empty = sel ? bus1.deck_empty : bus8.deck_empty;
  assign v_value = sel ? bus1.card_value : bus8.card_value;
  assign v_rank  = sel ? bus1.card_rank  : bus8.card_rank;
  assign v_left  = sel ? bus1.cards_left : bus8.cards_left;

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge Clock or posedge reset) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lfsr_adv(lfsr_m);
  end

  function automatic logic [4:0] ref_value(input int r);
    if (r == 0) return 5'd1;
    if (r >= 10) return 5'd10;
    return 5'(r + 1);
  endfunction

  // Which card the deck rules pick for a request made while the LFSR shows l_now,
  // and how many cycles after the request the card appears.
  function automatic void predict(input logic [15:0] l_now, input int max_tries,
                                  output int rank, output int lat);
    logic [15:0] l;
    int t, tries, idx;
    l = lfsr_adv(l_now);
    t = 1;
    tries = 0;
    rank = -1;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      idx = int'(l[3:0]);
      if (idx < 13 && rem[idx] > 0) begin
        rank = idx;
        lat = t + 1;
        return;
      end
      tries++;
      if (tries == max_tries) break;
      l = lfsr_adv(l);
      t++;
    end
    idx = int'(l[3:0]) % 13;
    for (int s = 0; s < 13; s++) begin
      t++;
      if (rem[idx] > 0) begin
        rank = idx;
        lat = t + 1;
        return;
      end
      idx = (idx + 1) % 13;
    end
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_full_deck();
    for (int r = 0; r < 13; r++) begin
      rem[r] = 4;
      seen[r] = 0;
    end
    sum_val = 0;
    left_m = 52;
  endtask

  // Monitor: every card_valid pulse must match the oldest expected card.
  always @(negedge Clock) begin
    if (!reset && v_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rank %0d, required no card (cycle %0d)", v_rank, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("card_rank", int'(v_rank), int'(mon_e.rank));
        chk("card_value", int'(v_value), int'(mon_e.value));
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("cards_left", int'(v_left), int'(mon_e.left));
        $display("card: rank %0d value %0d cycle %0d left %0d", v_rank, v_value, cyc, v_left);
      end
      if (v_rank < 4'd13) seen[v_rank] = seen[v_rank] + 1;
      sum_val = sum_val + int'(v_value);
    end
  end

  // Caller is positioned at a negedge; reset is raised immediately.
  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    model_full_deck();
    repeat (2) @(negedge Clock);
    reset = 1'b0;
    #1;
    chk("rst_cards_left", int'(v_left), 52);
    chk("rst_busy", int'(v_busy), 0);
    chk("rst_card_valid", int'(v_valid), 0);
    chk("rst_deck_empty", int'(v_empty), 0);
    chk("rst_lfsr", int'(sel ? dut1.u_lfsr.q : dut8.u_lfsr.q), 16'hACE1);
    @(negedge Clock);
  endtask

  // Caller is at a negedge with the dealer idle; req is held for k cycles (1..3).
  task automatic draw(input int k);
    int   rank, lat;
    exp_t e;
    bit   got;
    predict(lfsr_m, sel ? 1 : 8, rank, lat);
    e.rank  = 4'(rank);
    e.value = ref_value(rank);
    e.cyc   = cyc + lat;
    rem[rank]--;
    left_m--;
    e.left  = 6'(left_m);
    sb.push_back(e);
    req = 1'b1;
    got = 1'b0;
    for (int j = 1; j <= k; j++) begin
      @(negedge Clock);
      if (j == 1) chk("busy_after_req", int'(v_busy), 1);
      if (j == k) req = 1'b0;
      if (v_valid) got = 1'b1;
    end
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge Clock);
      if (v_valid) got = 1'b1;
    end
    if (!got) begin
      chk("draw_timeout", 0, 1);
      sb.delete();
    end
    @(negedge Clock);
  endtask

  task automatic draw_random();
    draw(int'($urandom_range(1, 3)));
    repeat ($urandom_range(0, 3)) @(negedge Clock);
  endtask

  task automatic check_full_deck_seen();
    for (int r = 0; r < 13; r++) chk($sformatf("rank%0d_seen", r), seen[r], 4);
    chk("deck_value_sum", sum_val, 340);
    chk("empty_cards_left", int'(v_left), 0);
    chk("empty_flag", int'(v_empty), 1);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    shuffle = 1'b0;
    sel     = 1'b0;
    @(negedge Clock);
    do_reset();

    // A few cards with random gaps and req held while busy.
    for (int n = 0; n < 5; n++) draw_random();

    // Reset lands while a draw is in flight; that card must never appear.
    req = 1'b1;
    @(negedge Clock);
    req = 1'b0;
    do_reset();

    // Whole deck, then a request against the empty deck.
    for (int n = 0; n < 52; n++) draw_random();
    check_full_deck_seen();
    req = 1'b1;
    @(negedge Clock);
    req = 1'b0;
    repeat (30) @(negedge Clock);
    chk("empty_req_busy", int'(v_busy), 0);
    chk("empty_req_left", int'(v_left), 0);

    // Refill, deal 50, then abort a draw with shuffle.
    shuffle = 1'b1;
    @(negedge Clock);
    shuffle = 1'b0;
    model_full_deck();
    chk("shuffle_left", int'(v_left), 52);
    for (int n = 0; n < 50; n++) draw_random();
    req = 1'b1;
    @(negedge Clock);
    req = 1'b0;
    shuffle = 1'b1;
    @(negedge Clock);
    shuffle = 1'b0;
    model_full_deck();
    repeat (30) @(negedge Clock);
    chk("abort_left", int'(v_left), 52);
    chk("abort_busy", int'(v_busy), 0);
    draw(1);
    draw(2);
    chk("after_abort_left", int'(v_left), 50);

    // MAX_TRIES=1 instance: scan fallback carries the sparse end of the deck.
    sel = 1'b1;
    do_reset();
    for (int n = 0; n < 52; n++) draw(1);
    check_full_deck_seen();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
